// File: rtl/i2c_bus_recovery_pkg.sv
// Shared definitions for the I2C bus-recovery block: FSM encoding, defaults
// and small decode helpers used to derive registered line controls.
package i2c_bus_recovery_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCL_LOW,
    ST_SCL_HIGH,
    ST_STOP_A,
    ST_STOP_B,
    ST_STOP_C,
    ST_DONE,
    ST_FAIL
  } state_t;

  localparam int MAX_PULSES_DEFAULT = 9;

  function automatic logic drives_scl(input state_t s);
    return (s == ST_SCL_LOW) || (s == ST_STOP_A);
  endfunction

  function automatic logic drives_sda(input state_t s);
    return (s == ST_STOP_A) || (s == ST_STOP_B);
  endfunction

  function automatic logic owns_bus(input state_t s);
    return (s != ST_IDLE) && (s != ST_DONE) && (s != ST_FAIL);
  endfunction

endpackage

// File: rtl/i2c_bus_recovery_sync2.sv
// Two-flop synchroniser for an open-drain pad input; resets to the idle-high
// bus level so a reset never looks like a stuck-low line.
module i2c_sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so both flops sample
  // their inputs from the same clock edge and the chain really is two deep.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta <= 1'b1;
      q_o  <= 1'b1;
    end else begin
      meta <= d_i;
      q_o  <= meta;
    end
  end

endmodule

// File: rtl/i2c_bus_recovery.sv
// I2C bus recovery: clocks SCL until a slave releases SDA, then issues STOP
// and pulses start_o so the downstream reset generator resets the master.
module i2c_bus_recovery
  import i2c_bus_recovery_pkg::*;
#(
  parameter int CLK_DIV      = 125,
  parameter int STUCK_CYCLES = 50000,
  parameter int MAX_PULSES   = MAX_PULSES_DEFAULT
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       busy_i,
  input  logic       force_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_oe_o,
  output logic       sda_oe_o,
  output logic       active_o,
  output logic       start_o,
  output logic       done_o,
  output logic       fail_o,
  output logic [3:0] pulses_o
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int WD_W  = $clog2(STUCK_CYCLES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [WD_W-1:0]  WD_LAST    = WD_W'(STUCK_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_SAT     = WD_W'(STUCK_CYCLES);
  localparam logic [3:0]       PULSE_LAST = 4'(MAX_PULSES);

  logic             scl_s, sda_s;
  logic             force_q, scl_seen;
  logic [DIV_W-1:0] div_cnt;
  logic [WD_W-1:0]  wd_cnt;
  state_t           state, nxt;
  logic             force_rise, wd_run, hold_wait, div_done;

  i2c_sync2 u_scl_sync (.clk_i(clk_i), .rst_i(rst_i), .d_i(scl_i), .q_o(scl_s));
  i2c_sync2 u_sda_sync (.clk_i(clk_i), .rst_i(rst_i), .d_i(sda_i), .q_o(sda_s));

  assign force_rise = force_i & ~force_q;
  assign wd_run     = en_i & ~busy_i & ~sda_s;
  assign div_done   = (div_cnt == DIV_LAST);
  // wd_cnt doubles as the SCL-stretch timeout while waiting for SCL to rise.
  assign hold_wait  = ((state == ST_SCL_HIGH) || (state == ST_STOP_B)) && !scl_seen;

  // NOTE: nxt gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:
        if (en_i && (force_rise || (wd_run && wd_cnt == WD_LAST))) nxt = ST_SCL_LOW;
      ST_SCL_LOW:
        if (div_done) nxt = ST_SCL_HIGH;
      ST_SCL_HIGH:
        if (hold_wait) begin
          if (!scl_s && wd_cnt == WD_LAST) nxt = ST_FAIL;
        end else if (div_done) begin
          if (sda_s)                       nxt = ST_STOP_A;
          else if (pulses_o == PULSE_LAST) nxt = ST_FAIL;
          else                             nxt = ST_SCL_LOW;
        end
      ST_STOP_A:
        if (div_done) nxt = ST_STOP_B;
      ST_STOP_B:
        if (hold_wait) begin
          if (!scl_s && wd_cnt == WD_LAST) nxt = ST_FAIL;
        end else if (div_done) begin
          nxt = ST_STOP_C;
        end
      ST_STOP_C:
        if (div_done) nxt = sda_s ? ST_DONE : ST_FAIL;
      default:
        nxt = ST_IDLE;
    endcase
    // Disable wins over everything: abort silently back to IDLE.
    if (!en_i) nxt = ST_IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      force_q  <= 1'b0;
      scl_seen <= 1'b0;
      div_cnt  <= '0;
      wd_cnt   <= '0;
      scl_oe_o <= 1'b0;
      sda_oe_o <= 1'b0;
      active_o <= 1'b0;
      start_o  <= 1'b0;
      done_o   <= 1'b0;
      fail_o   <= 1'b0;
      pulses_o <= 4'd0;
    end else begin
      state    <= nxt;
      force_q  <= force_i;
      div_cnt  <= (nxt != state || hold_wait) ? '0 : div_cnt + DIV_W'(1);
      scl_seen <= (nxt == state) && (scl_seen || (hold_wait && scl_s));

      if (nxt == state && ((state == ST_IDLE && wd_run) || hold_wait))
        wd_cnt <= (wd_cnt == WD_SAT) ? wd_cnt : wd_cnt + WD_W'(1);
      else
        wd_cnt <= '0;

      // Line controls are decoded from the next state so they are registered.
      scl_oe_o <= drives_scl(nxt);
      sda_oe_o <= drives_sda(nxt);
      active_o <= owns_bus(nxt);
      start_o  <= (nxt == ST_DONE);
      done_o   <= (nxt == ST_DONE) || (nxt == ST_FAIL);

      if (state == ST_IDLE && nxt == ST_SCL_LOW) begin
        pulses_o <= 4'd0;
        fail_o   <= 1'b0;
      end else if (state == ST_SCL_LOW && nxt == ST_SCL_HIGH) begin
        pulses_o <= pulses_o + 4'd1;
      end
      if (nxt == ST_FAIL) fail_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_i2c_bus_recovery.sv
// Scoreboard bench for i2c_bus_recovery: a slave model holds SDA low for a
// chosen number of SCL highs; a monitor checks each finished sequence.
module tb_i2c_bus_recovery;

  localparam int CLK_DIV = 4;
  localparam int STUCK   = 20;
  localparam int MAXP    = 9;

  logic       clk_i = 1'b0;
  logic       rst_i, en_i, busy_i, force_i;
  logic       scl_i, sda_i;
  logic       scl_oe_o, sda_oe_o, active_o, start_o, done_o, fail_o;
  logic [3:0] pulses_o;

  logic scl_hold, slave_stuck, slave_low, scl_prev;
  int   release_after, rises;

  typedef struct {
    bit start;
    bit fail;
    int pulses;
    bit stop;
  } exp_t;

  exp_t sb_q[$];
  int   vectors, miscompares, done_cnt;
  int   obs_pulses;
  bit   stop_seen, act_prev, scl_oe_prev, sda_oe_prev;

  i2c_bus_recovery #(.CLK_DIV(CLK_DIV), .STUCK_CYCLES(STUCK), .MAX_PULSES(MAXP)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .busy_i(busy_i), .force_i(force_i),
    .scl_i(scl_i), .sda_i(sda_i), .scl_oe_o(scl_oe_o), .sda_oe_o(sda_oe_o),
    .active_o(active_o), .start_o(start_o), .done_o(done_o), .fail_o(fail_o),
    .pulses_o(pulses_o)
  );

  always #5 clk_i = ~clk_i;

  // Open-drain wired-AND bus with an external SCL jam and a stuck slave.
  assign scl_i     = ~(scl_oe_o | scl_hold);
  assign slave_low = slave_stuck && (rises < release_after);
  assign sda_i     = ~(sda_oe_o | slave_low);

  initial begin
    scl_prev = 1'b1;
    rises    = 0;
  end

  // Slave lets go of SDA once it has seen release_after SCL highs this sequence.
  always @(negedge clk_i) begin
    scl_prev <= scl_i;
    if (!active_o)               rises <= 0;
    else if (scl_i && !scl_prev) rises <= rises + 1;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Outcome of one recovery sequence from the slave behaviour alone.
  function automatic exp_t predict(input int rel, input bit jam);
    exp_t e;
    if (jam)              e = '{start: 1'b0, fail: 1'b1, pulses: 1,   stop: 1'b0};
    else if (rel <= MAXP) e = '{start: 1'b1, fail: 1'b0, pulses: (rel < 1) ? 1 : rel, stop: 1'b1};
    else                  e = '{start: 1'b0, fail: 1'b1, pulses: MAXP, stop: 1'b0};
    return e;
  endfunction

  // Monitor: observes the bus and checks every done_o against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (active_o && !act_prev) begin
        obs_pulses = 0;
        stop_seen  = 1'b0;
      end
      if (scl_oe_o && !scl_oe_prev && !sda_oe_o) obs_pulses++;
      if (sda_oe_prev && !sda_oe_o && scl_i)     stop_seen = 1'b1;
      if (start_o) check("done_with_start", done_o, 1);
      if (done_o) begin
        done_cnt++;
        if (sb_q.size() == 0) begin
          check("unexpected_done_queue", sb_q.size(), 1);
        end else begin
          e = sb_q.pop_front();
          check("start_o",     start_o,    e.start);
          check("fail_o",      fail_o,     e.fail);
          check("pulses_o",    pulses_o,   e.pulses);
          check("bus_pulses",  obs_pulses, e.pulses);
          check("stop_on_bus", stop_seen,  e.stop);
        end
      end
      act_prev    = active_o;
      scl_oe_prev = scl_oe_o;
      sda_oe_prev = sda_oe_o;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic wait_active(input int exp_edges, input string nm);
    int n = 0;
    while (!active_o && n < 300) begin
      @(posedge clk_i);
      n++;
      @(negedge clk_i);
    end
    check(nm, n, exp_edges);
  endtask

  task automatic wait_done(input string nm);
    int d0 = done_cnt;
    int n  = 0;
    while (done_cnt == d0 && n < 3000) begin
      @(negedge clk_i);
      #1;
      n++;
    end
    check(nm, done_cnt != d0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: bench did not finish, got t=%0t", $time);
    $fatal(1, "global timeout");
  end

  initial begin
    int n, rel;
    bit use_force;
    rst_i = 1'b1; en_i = 1'b0; busy_i = 1'b0; force_i = 1'b0;
    scl_hold = 1'b0; slave_stuck = 1'b0; release_after = 0;
    #23;
    check("rst_lines_flags", {scl_oe_o, sda_oe_o, active_o, start_o, done_o, fail_o}, 0);
    check("rst_pulses", pulses_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0; en_i = 1'b1;
    idle(5);

    // Watchdog recovery, slave lets go on the 3rd SCL high.
    slave_stuck = 1'b1; release_after = 3;
    sb_q.push_back(predict(3, 1'b0));
    wait_active(STUCK + 2, "wd_latency");
    wait_done("wd_done");
    slave_stuck = 1'b0;
    idle(5);

    // Permanently stuck SDA: fail after MAXP pulses, then a retry.
    slave_stuck = 1'b1; release_after = 99;
    sb_q.push_back(predict(99, 1'b0));
    wait_active(STUCK + 2, "stuck_latency");
    wait_done("stuck_done");
    wait_active(STUCK + 1, "retry_latency");
    check("retry_fail_cleared", fail_o, 0);
    check("retry_pulses_cleared", pulses_o, 0);
    en_i = 1'b0;
    @(negedge clk_i);
    check("retry_abort_active", active_o, 0);
    slave_stuck = 1'b0; en_i = 1'b1;
    idle(5);

    // Software force while busy with SDA already high.
    busy_i = 1'b1; force_i = 1'b1;
    sb_q.push_back(predict(0, 1'b0));
    wait_active(1, "force_latency");
    force_i = 1'b0;
    wait_done("force_done");
    busy_i = 1'b0;
    idle(5);

    // busy_i inhibits the watchdog; dropping it starts the count.
    busy_i = 1'b1; slave_stuck = 1'b1; release_after = 2;
    idle(100);
    check("busy_inhibits", active_o, 0);
    sb_q.push_back(predict(2, 1'b0));
    busy_i = 1'b0;
    wait_active(STUCK, "busy_release_latency");
    wait_done("busy_done");
    slave_stuck = 1'b0;
    idle(5);

    // SCL jammed low externally during SCL_HIGH.
    slave_stuck = 1'b1; release_after = 99;
    sb_q.push_back(predict(99, 1'b1));
    wait_active(STUCK + 2, "jam_latency");
    scl_hold = 1'b1;
    wait_done("jam_done");
    check("jam_scl_released", scl_oe_o, 0);
    scl_hold = 1'b0; slave_stuck = 1'b0;
    idle(5);

    // en_i dropped during the 2nd SCL high.
    slave_stuck = 1'b1; release_after = 99; force_i = 1'b1;
    wait_active(1, "abort_force_latency");
    force_i = 1'b0;
    n = 0;
    while (!(pulses_o == 4'd2 && !scl_oe_o) && n < 500) begin
      @(negedge clk_i);
      n++;
    end
    check("abort_reached_pulse2", n < 500, 1);
    en_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    check("abort_lines", {scl_oe_o, sda_oe_o, active_o}, 0);
    check("abort_pulses_hold", pulses_o, 2);
    check("abort_fail_unchanged", fail_o, 0);
    slave_stuck = 1'b0; en_i = 1'b1;
    idle(5);

    // Reset asserted in STOP_B releases everything asynchronously.
    slave_stuck = 1'b1; release_after = 2; force_i = 1'b1;
    wait_active(1, "rst_force_latency");
    force_i = 1'b0;
    n = 0;
    while (!(!scl_oe_o && sda_oe_o) && n < 500) begin
      @(negedge clk_i);
      n++;
    end
    check("rst_reached_stop_b", n < 500, 1);
    #1 rst_i = 1'b1; slave_stuck = 1'b0;
    #1;
    check("rst_mid_lines", {scl_oe_o, sda_oe_o, active_o, start_o, done_o}, 0);
    check("rst_mid_pulses", pulses_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    idle(5);

    // Randomised sequences: mixed triggers and release points incl. failures.
    for (int i = 0; i < 8; i++) begin
      rel       = int'($urandom_range(1, 11));
      use_force = 1'($urandom_range(0, 1));
      slave_stuck = 1'b1; release_after = rel;
      sb_q.push_back(predict(rel, 1'b0));
      if (use_force) begin
        busy_i  = 1'($urandom_range(0, 1));
        force_i = 1'b1;
        wait_active(1, "rand_force_latency");
        force_i = 1'b0;
      end else begin
        wait_active(STUCK + 2, "rand_wd_latency");
      end
      wait_done("rand_done");
      slave_stuck = 1'b0; busy_i = 1'b0;
      idle(5);
    end

    idle(10);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
